// File: rtl/network_data_pkg.sv
// Shared definitions for the NoC <-> AXIS data path (upsizer and downsizer).
// Holds flit type codes, flit field offsets/widths, per-flit byte counts,
// packed flit layouts and the pad-field helpers.
package network_data_pkg;

    localparam int unsigned NOC_W       = 64;
    localparam int unsigned AXIS_W      = 8;
    localparam int unsigned FLIT_TYPE_W = 2;

    // Flit type codes
    localparam logic [1:0] HEADER      = 2'b00;
    localparam logic [1:0] BODY        = 2'b01;
    localparam logic [1:0] TAIL        = 2'b10;
    localparam logic [1:0] HEADER_TAIL = 2'b11;

    // Data bytes carried per flit kind
    localparam int unsigned HDR_BYTES  = 4;
    localparam int unsigned BODY_BYTES = 8;
    localparam int unsigned TAIL_BYTES = 7;

    // Header / header-tail field placement
    localparam int unsigned HDR_PAD_LSB   = 32;
    localparam int unsigned HDR_PAD_W     = 4;
    localparam int unsigned HDR_LAST_BIT  = 36;
    localparam int unsigned HDR_TID_LSB   = 37;
    localparam int unsigned HDR_TID_W     = 5;
    localparam int unsigned HDR_RSVD_W    = 11;
    localparam int unsigned HDR_TDEST_LSB = 53;
    localparam int unsigned HDR_TDEST_W   = 11;

    // Tail field placement
    localparam int unsigned TAIL_PAD_LSB  = 56;
    localparam int unsigned TAIL_PAD_W    = 7;
    localparam int unsigned TAIL_LAST_BIT = 63;

    typedef struct packed {
        logic [HDR_TDEST_W-1:0]     tdest;
        logic [HDR_RSVD_W-1:0]      rsvd;
        logic [HDR_TID_W-1:0]       tid;
        logic                       last;
        logic [HDR_PAD_W-1:0]       pad;
        logic [8*HDR_BYTES-1:0]     data;
    } hdr_flit_t;

    typedef struct packed {
        logic                       last;
        logic [TAIL_PAD_W-1:0]      pad;
        logic [8*TAIL_BYTES-1:0]    data;
    } tail_flit_t;

    // Thermometer pad: every byte position at or above cnt is padding.
    function automatic logic [HDR_PAD_W-1:0] hdr_pad(input logic [3:0] cnt);
        logic [HDR_PAD_W-1:0] p;
        for (int i = 0; i < int'(HDR_PAD_W); i++) begin
            p[i] = (4'(i) >= cnt);
        end
        return p;
    endfunction

    function automatic logic [TAIL_PAD_W-1:0] tail_pad(input logic [3:0] cnt);
        logic [TAIL_PAD_W-1:0] p;
        for (int i = 0; i < int'(TAIL_PAD_W); i++) begin
            p[i] = (4'(i) >= cnt);
        end
        return p;
    endfunction

endpackage

// File: rtl/noc_flit_out_reg.sv
// Output flit register with valid/ready hold semantics.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   load            capture load_flit/load_type (only legal when free_c)
//   load_flit/type  next flit and its type
//   ready           downstream accepts the presented flit
//   valid/flit/flit_type  registered outputs, held until valid & ready
//   free_c          register can take a new flit this cycle
module noc_flit_out_reg #(
    parameter int unsigned DataWidth = 64,
    parameter int unsigned TypeWidth = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic [DataWidth-1:0] load_flit,
    input  logic [TypeWidth-1:0] load_type,
    input  logic                 ready,
    output logic                 valid,
    output logic [DataWidth-1:0] flit,
    output logic [TypeWidth-1:0] flit_type,
    output logic                 free_c
);

    // Empty, or the current flit leaves at this edge.
    assign free_c = !valid || ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            flit      <= '0;
            flit_type <= '0;
        end else if (load) begin
            valid     <= 1'b1;
            flit      <= load_flit;
            flit_type <= load_type;
        end else if (ready) begin
            valid     <= 1'b0;
        end
    end

endmodule

// File: rtl/axis_network_data_upsizer.sv
// Packs a byte-wide AXI Stream into 64-bit NoC flits (HEADER/HEADER_TAIL,
// BODY, TAIL); transmit-side counterpart of network_data_axis_downsizer.
// Ports:
//   clk_noc, rst_noc          clock, synchronous active-high reset
//   s_axis_*                  byte-wide AXIS slave (tdata/tvalid/tready/
//                             tlast/tkeep/tid/tdest)
//   network_flit_type_o       flit type of the presented flit
//   network_flit_o            presented flit
//   network_valid_o           flit valid
//   network_ready_i           router accepts flit
module axis_network_data_upsizer
    import network_data_pkg::*;
#(
    parameter int unsigned AxisDataWidth = 8,
    parameter int unsigned NocDataWidth  = 64,
    parameter int unsigned flitTypeSize  = 2,
    parameter int unsigned KeepEnable    = 0,
    parameter int unsigned TIdWidth      = 5,
    parameter int unsigned TDestWidth    = 11
) (
    input  logic                     clk_noc,
    input  logic                     rst_noc,
    input  logic [AxisDataWidth-1:0] s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    input  logic                     s_axis_tlast,
    input  logic                     s_axis_tkeep,
    input  logic [TIdWidth-1:0]      s_axis_tid,
    input  logic [TDestWidth-1:0]    s_axis_tdest,
    output logic [flitTypeSize-1:0]  network_flit_type_o,
    output logic [NocDataWidth-1:0]  network_flit_o,
    output logic                     network_valid_o,
    input  logic                     network_ready_i
);

    typedef enum logic [1:0] {
        ST_HEAD,
        ST_BODY,
        ST_ETAIL
    } up_state_e;

    up_state_e                state_q, state_d;
    logic [3:0]               byte_cnt_q, byte_cnt_d;
    logic [NOC_W-1:0]         buf_q, buf_d;
    logic [HDR_TID_W-1:0]     tid_q, tid_d;
    logic [HDR_TDEST_W-1:0]   tdest_q, tdest_d;
    logic                     open_q, open_d;
    logic                     asm_valid_q, asm_valid_d;
    logic [NOC_W-1:0]         asm_flit_q, asm_flit_d;
    logic [FLIT_TYPE_W-1:0]   asm_type_q, asm_type_d;

    logic                     accept;
    logic                     has_byte;
    logic [3:0]               cnt_new;
    logic [NOC_W-1:0]         data_new;
    logic [HDR_TID_W-1:0]     tid_sel;
    logic [HDR_TDEST_W-1:0]   tdest_sel;
    logic                     done;
    logic [NOC_W-1:0]         done_flit;
    logic [FLIT_TYPE_W-1:0]   done_type;
    hdr_flit_t                hdr;
    tail_flit_t               tl;
    logic                     load;
    logic [NOC_W-1:0]         load_flit;
    logic [FLIT_TYPE_W-1:0]   load_type;
    logic                     out_free;

    // Input stalls only while a finished flit waits in the assembly register,
    // during the extra tail cycle, and in reset.
    assign s_axis_tready = !rst_noc && (state_q != ST_ETAIL) && !asm_valid_q;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign has_byte      = accept && ((KeepEnable == 0) ? 1'b1 : s_axis_tkeep);

    // Packet id/dest come from the incoming beat when it is the first one.
    assign tid_sel   = open_q ? tid_q   : HDR_TID_W'(s_axis_tid);
    assign tdest_sel = open_q ? tdest_q : HDR_TDEST_W'(s_axis_tdest);

    // Next-state, packing and output-register steering.
    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        buf_d       = buf_q;
        tid_d       = tid_q;
        tdest_d     = tdest_q;
        open_d      = open_q;
        asm_valid_d = asm_valid_q;
        asm_flit_d  = asm_flit_q;
        asm_type_d  = asm_type_q;
        done        = 1'b0;
        done_flit   = '0;
        done_type   = HEADER;
        load        = 1'b0;
        load_flit   = '0;
        load_type   = HEADER;
        hdr         = '0;
        tl          = '0;

        cnt_new  = byte_cnt_q + 4'(has_byte);
        data_new = buf_q;
        if (has_byte) begin
            data_new[{byte_cnt_q[2:0], 3'b000} +: 8] = 8'(s_axis_tdata);
        end

        if (accept) begin
            buf_d      = data_new;
            byte_cnt_d = cnt_new;
            open_d     = !s_axis_tlast;
            if (!open_q) begin
                tid_d   = tid_sel;
                tdest_d = tdest_sel;
            end
            case (state_q)
                ST_HEAD: begin
                    if (s_axis_tlast || (cnt_new == 4'(HDR_BYTES))) begin
                        hdr.tdest  = tdest_sel;
                        hdr.tid    = tid_sel;
                        hdr.last   = s_axis_tlast;
                        hdr.pad    = s_axis_tlast ? hdr_pad(cnt_new) : '0;
                        hdr.data   = data_new[8*HDR_BYTES-1:0];
                        done       = 1'b1;
                        done_flit  = hdr;
                        done_type  = s_axis_tlast ? HEADER_TAIL : HEADER;
                        state_d    = s_axis_tlast ? ST_HEAD : ST_BODY;
                        buf_d      = '0;
                        byte_cnt_d = '0;
                    end
                end
                ST_BODY: begin
                    if (cnt_new == 4'(BODY_BYTES)) begin
                        // A full body flit cannot also carry last, so a
                        // padding-only tail follows.
                        done       = 1'b1;
                        done_flit  = data_new;
                        done_type  = BODY;
                        state_d    = s_axis_tlast ? ST_ETAIL : ST_BODY;
                        buf_d      = '0;
                        byte_cnt_d = '0;
                    end else if (s_axis_tlast) begin
                        tl.last    = 1'b1;
                        tl.pad     = tail_pad(cnt_new);
                        tl.data    = data_new[8*TAIL_BYTES-1:0];
                        done       = 1'b1;
                        done_flit  = tl;
                        done_type  = TAIL;
                        state_d    = ST_HEAD;
                        buf_d      = '0;
                        byte_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end

        // Empty tail: only produced once any held flit has drained.
        if ((state_q == ST_ETAIL) && !asm_valid_q) begin
            tl.last   = 1'b1;
            tl.pad    = '1;
            done      = 1'b1;
            done_flit = tl;
            done_type = TAIL;
        end

        if (asm_valid_q) begin
            if (out_free) begin
                load        = 1'b1;
                load_flit   = asm_flit_q;
                load_type   = asm_type_q;
                asm_valid_d = 1'b0;
            end
        end else if (done) begin
            if (out_free) begin
                load      = 1'b1;
                load_flit = done_flit;
                load_type = done_type;
                if (state_q == ST_ETAIL) begin
                    state_d = ST_HEAD;
                end
            end else if (state_q != ST_ETAIL) begin
                asm_valid_d = 1'b1;
                asm_flit_d  = done_flit;
                asm_type_d  = done_type;
            end
        end
    end

    // State and assembly registers.
    always_ff @(posedge clk_noc) begin
        if (rst_noc) begin
            state_q     <= ST_HEAD;
            byte_cnt_q  <= '0;
            buf_q       <= '0;
            tid_q       <= '0;
            tdest_q     <= '0;
            open_q      <= 1'b0;
            asm_valid_q <= 1'b0;
            asm_flit_q  <= '0;
            asm_type_q  <= HEADER;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            buf_q       <= buf_d;
            tid_q       <= tid_d;
            tdest_q     <= tdest_d;
            open_q      <= open_d;
            asm_valid_q <= asm_valid_d;
            asm_flit_q  <= asm_flit_d;
            asm_type_q  <= asm_type_d;
        end
    end

    noc_flit_out_reg #(
        .DataWidth (NocDataWidth),
        .TypeWidth (flitTypeSize)
    ) u_out_reg (
        .clk       (clk_noc),
        .rst       (rst_noc),
        .load      (load),
        .load_flit (NocDataWidth'(load_flit)),
        .load_type (flitTypeSize'(load_type)),
        .ready     (network_ready_i),
        .valid     (network_valid_o),
        .flit      (network_flit_o),
        .flit_type (network_flit_type_o),
        .free_c    (out_free)
    );

endmodule

// File: tb/tb_axis_network_data_upsizer.sv
// Scoreboard bench for axis_network_data_upsizer: directed packets push
// hand-computed flits; a monitor pops and compares at every presented flit.
module tb_axis_network_data_upsizer;

    logic        clk_noc;
    logic        rst_noc;

    // Main DUT (KeepEnable=0)
    logic [7:0]  m_tdata;
    logic        m_tvalid, m_tready, m_tlast, m_tkeep;
    logic [4:0]  m_tid;
    logic [10:0] m_tdest;
    logic [1:0]  m_type;
    logic [63:0] m_flit;
    logic        m_valid, m_ready;

    // Second DUT (KeepEnable=1)
    logic [7:0]  k_tdata;
    logic        k_tvalid, k_tready, k_tlast, k_tkeep;
    logic [4:0]  k_tid;
    logic [10:0] k_tdest;
    logic [1:0]  k_type;
    logic [63:0] k_flit;
    logic        k_valid, k_ready;

    typedef struct packed {
        logic [1:0]  t;
        logic [63:0] f;
    } exp_t;

    exp_t exp_m[$];
    exp_t exp_k[$];
    int   errors = 0;
    int   checks = 0;
    int   stall_cycles = 0;

    axis_network_data_upsizer #(.KeepEnable(0)) dut_m (
        .clk_noc             (clk_noc),
        .rst_noc             (rst_noc),
        .s_axis_tdata        (m_tdata),
        .s_axis_tvalid       (m_tvalid),
        .s_axis_tready       (m_tready),
        .s_axis_tlast        (m_tlast),
        .s_axis_tkeep        (m_tkeep),
        .s_axis_tid          (m_tid),
        .s_axis_tdest        (m_tdest),
        .network_flit_type_o (m_type),
        .network_flit_o      (m_flit),
        .network_valid_o     (m_valid),
        .network_ready_i     (m_ready)
    );

    axis_network_data_upsizer #(.KeepEnable(1)) dut_k (
        .clk_noc             (clk_noc),
        .rst_noc             (rst_noc),
        .s_axis_tdata        (k_tdata),
        .s_axis_tvalid       (k_tvalid),
        .s_axis_tready       (k_tready),
        .s_axis_tlast        (k_tlast),
        .s_axis_tkeep        (k_tkeep),
        .s_axis_tid          (k_tid),
        .s_axis_tdest        (k_tdest),
        .network_flit_type_o (k_type),
        .network_flit_o      (k_flit),
        .network_valid_o     (k_valid),
        .network_ready_i     (k_ready)
    );

    initial begin
        clk_noc = 1'b0;
        forever #5 clk_noc = ~clk_noc;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare every presented flit with the queue head; pop on transfer.
    task automatic monitor();
        forever begin
            @(negedge clk_noc);
            if (m_valid === 1'b1) begin
                if (exp_m.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flit_m: got type=%b flit=%h, none expected", m_type, m_flit);
                end else begin
                    check("flit_type_m", 64'(m_type), 64'(exp_m[0].t));
                    check("flit_data_m", m_flit, exp_m[0].f);
                    if (m_ready === 1'b1) void'(exp_m.pop_front());
                end
            end
            if (k_valid === 1'b1) begin
                if (exp_k.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_flit_k: got type=%b flit=%h, none expected", k_type, k_flit);
                end else begin
                    check("flit_type_k", 64'(k_type), 64'(exp_k[0].t));
                    check("flit_data_k", k_flit, exp_k[0].f);
                    if (k_ready === 1'b1) void'(exp_k.pop_front());
                end
            end
        end
    endtask

    // Router-side ready for the main DUT; low while stall_cycles runs down.
    task automatic ready_ctl();
        m_ready = 1'b1;
        forever begin
            @(posedge clk_noc);
            #2;
            if (stall_cycles > 0) begin
                m_ready = 1'b0;
                stall_cycles--;
            end else begin
                m_ready = 1'b1;
            end
        end
    endtask

    task automatic push(input bit sel, input logic [1:0] t, input logic [63:0] f);
        exp_t e;
        e.t = t;
        e.f = f;
        if (sel) exp_k.push_back(e);
        else     exp_m.push_back(e);
    endtask

    task automatic send(input bit sel, input logic [7:0] d, input bit last, input bit keep,
                        input logic [4:0] tid, input logic [10:0] tdest, output int waits);
        bit accepted;
        accepted = 1'b0;
        waits    = 0;
        if (sel) begin
            k_tdata = d; k_tlast = last; k_tkeep = keep; k_tid = tid; k_tdest = tdest; k_tvalid = 1'b1;
        end else begin
            m_tdata = d; m_tlast = last; m_tkeep = keep; m_tid = tid; m_tdest = tdest; m_tvalid = 1'b1;
        end
        while (!accepted && waits < 200) begin
            @(negedge clk_noc);
            if ((sel ? k_tready : m_tready) === 1'b1) begin
                @(posedge clk_noc);
                #1;
                accepted = 1'b1;
            end else begin
                waits++;
            end
        end
        if (!accepted) begin
            checks++;
            errors++;
            $display("FAIL beat_accept_timeout: got no tready expected accept within 200 cycles");
        end
        if (sel) k_tvalid = 1'b0;
        else     m_tvalid = 1'b0;
    endtask

    task automatic send_seq(input bit sel, input int base, input int step, input int n,
                            input logic [4:0] tid, input logic [10:0] tdest,
                            output int waits_total, output int first_stall);
        int w;
        waits_total = 0;
        first_stall = -1;
        for (int i = 0; i < n; i++) begin
            send(sel, 8'(base + i * step), (i == n - 1), 1'b1, tid, tdest, w);
            if (w > 0 && first_stall < 0) first_stall = i;
            waits_total += w;
        end
    endtask

    task automatic wait_drain();
        int c;
        c = 0;
        while ((exp_m.size() != 0 || exp_k.size() != 0) && c < 300) begin
            @(posedge clk_noc);
            #1;
            c++;
        end
        @(posedge clk_noc);
        #1;
    endtask

    initial begin
        int w, fs;
        rst_noc  = 1'b1;
        m_tdata  = '0; m_tvalid = 1'b1; m_tlast = 1'b0; m_tkeep = 1'b1; m_tid = '0; m_tdest = '0;
        k_tdata  = '0; k_tvalid = 1'b0; k_tlast = 1'b0; k_tkeep = 1'b1; k_tid = '0; k_tdest = '0;
        k_ready  = 1'b1;
        fork
            monitor();
            ready_ctl();
        join_none

        // Reset held 3 cycles with tvalid high
        repeat (3) begin
            @(negedge clk_noc);
            check("rst_tready", 64'(m_tready), 64'd0);
            check("rst_valid",  64'(m_valid),  64'd0);
            check("rst_flit",   m_flit,        64'd0);
            check("rst_type",   64'(m_type),   64'd0);
        end
        @(posedge clk_noc);
        #1;
        rst_noc  = 1'b0;
        m_tvalid = 1'b0;
        @(negedge clk_noc);
        check("tready_after_rst", 64'(m_tready), 64'd1);
        @(posedge clk_noc);
        #1;

        // 3-byte packet -> single HEADER_TAIL
        push(0, 2'b11, 64'h24600158_00332211);
        send_seq(0, 'h11, 'h11, 3, 5'h0A, 11'h123, w, fs);
        check("pkt3_waits", 64'(w), 64'd0);

        // 12-byte packet -> HEADER, BODY, empty TAIL with one stall
        push(0, 2'b00, 64'hFFE003E0_04030201);
        push(0, 2'b01, 64'h0C0B0A09_08070605);
        push(0, 2'b10, 64'hFF000000_00000000);
        send_seq(0, 1, 1, 12, 5'h1F, 11'h7FF, w, fs);
        check("pkt12_waits", 64'(w), 64'd0);
        @(negedge clk_noc);
        check("etail_stall", 64'(m_tready), 64'd0);
        @(negedge clk_noc);
        check("etail_release", 64'(m_tready), 64'd1);
        @(posedge clk_noc);
        #1;

        // 7-byte packet -> HEADER, TAIL with 3 bytes
        push(0, 2'b00, 64'h00200020_04030201);
        push(0, 2'b10, 64'hF8000000_00070605);
        send_seq(0, 1, 1, 7, 5'h01, 11'h001, w, fs);

        // 4-byte packet -> HEADER_TAIL with no padding
        push(0, 2'b11, 64'h24600150_A4A3A2A1);
        send_seq(0, 'hA1, 1, 4, 5'h0A, 11'h123, w, fs);
        wait_drain();

        // 20-byte packet under 20 cycles of backpressure
        push(0, 2'b00, 64'h80000060_24232221);
        push(0, 2'b01, 64'h2C2B2A29_28272625);
        push(0, 2'b01, 64'h34333231_302F2E2D);
        push(0, 2'b10, 64'hFF000000_00000000);
        stall_cycles = 20;
        send_seq(0, 'h21, 1, 20, 5'h03, 11'h400, w, fs);
        check("bp_first_stall_beat", 64'(fs), 64'd12);
        wait_drain();

        // tkeep ignored when KeepEnable=0
        push(0, 2'b11, 64'h24600158_00CCBBAA);
        send(0, 8'hAA, 1'b0, 1'b1, 5'h0A, 11'h123, w);
        send(0, 8'hBB, 1'b0, 1'b0, 5'h0A, 11'h123, w);
        send(0, 8'hCC, 1'b1, 1'b1, 5'h0A, 11'h123, w);

        // tkeep=0 beats dropped when KeepEnable=1
        push(1, 2'b11, 64'h2460015C_0000CCAA);
        send(1, 8'hAA, 1'b0, 1'b1, 5'h0A, 11'h123, w);
        send(1, 8'hBB, 1'b0, 1'b0, 5'h0A, 11'h123, w);
        send(1, 8'hCC, 1'b1, 1'b1, 5'h0A, 11'h123, w);

        // Lone tkeep=0 tlast beat -> empty HEADER_TAIL
        push(1, 2'b11, 64'h2460015F_00000000);
        send(1, 8'h55, 1'b1, 1'b0, 5'h0A, 11'h123, w);
        wait_drain();

        check("exp_m_drained", 64'(exp_m.size()), 64'd0);
        check("exp_k_drained", 64'(exp_k.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/axis_network_data_upsizer.md
# axis_network_data_upsizer

Packs a 1-byte-wide AXI Stream into 64-bit NoC flits for injection into the router local port; it is the transmit-side counterpart of `network_data_axis_downsizer`. Each tlast-delimited AXIS packet becomes one NoC packet:
- HEADER or HEADER_TAIL first flit, carrying tid, tdest and up to 4 bytes.
- Then BODY flits of 8 bytes each.
- Closed by a TAIL flit of up to 7 bytes, with padding and last fields filled in so the downsizer rebuilds the stream exactly.

## Interface
Parameters:
- AxisDataWidth, 8: TDATA width; only 8 is supported.
- NocDataWidth, 64: flit width; only 64 is supported.
- flitTypeSize, 2: flit type width.
- KeepEnable, 0: 1 means tkeep=0 beats are dropped; 0 means tkeep is ignored.
- TIdWidth, 5: tid width; low 5 bits are packed.
- TDestWidth, 11: tdest width; low 11 bits are packed.

Ports:
- clk_noc  in  1  clock. One clock only; reset is synchronous and active-high.
- rst_noc  in  1  synchronous active-high reset.
- s_axis_tdata  in  8  payload byte.
- s_axis_tvalid  in  1  beat valid.
- s_axis_tready  out  1  beat accepted.
- s_axis_tlast  in  1  last beat of packet.
- s_axis_tkeep  in  1  byte valid.
- s_axis_tid  in  TIdWidth  stream id.
- s_axis_tdest  in  TDestWidth  destination.
- network_flit_type_o  out  2  flit type: HEADER=00, BODY=01, TAIL=10, HEADER_TAIL=11.
- network_flit_o  out  64  flit.
- network_valid_o  out  1  flit valid.
- network_ready_i  in  1  router accepts flit.

## Operation
Flit layout (shared with the downsizer):
- HEADER and HEADER_TAIL:
  - data bytes in [31:0], byte i at [8i+:8].
  - pad field [35:32].
  - last bit [36].
  - tid [41:37].
  - [52:42] are zero.
  - tdest [63:53].
- BODY: 8 data bytes in [63:0].
- TAIL:
  - data bytes in [55:0].
  - pad field [62:56].
  - last bit [63].
- Pad field: bit i=1 for every byte position i that is padding, i.e. thermometer from the first pad byte upward. Pad bytes and unused bits are zero.
- The last bit is 1 in HEADER_TAIL and TAIL only.

Input capture and packing:
- tid and tdest are captured on the first accepted beat of a packet.
- An accepted beat is one with tvalid & tready.
- When KeepEnable=1:
  - A tkeep=0 beat adds no byte.
  - If it also carries tlast, it closes the packet with the bytes collected so far.

States:
- HEAD: collecting header bytes, byte_cnt 0..3.
  - 4th byte without tlast → emit HEADER; go to BODY.
  - tlast at byte count k (1..4) → emit HEADER_TAIL with pad bits k..3 set; go to HEAD.
  - tlast with zero bytes collected (KeepEnable=1 only) → HEADER_TAIL with pad 4'b1111.
- BODY: collecting body bytes, byte_cnt 0..7.
  - 8th byte without tlast → emit BODY.
  - tlast at byte count k (0..7) → emit TAIL with pad bits k..6 set; go to HEAD.
  - tlast on the 8th byte → emit BODY, go to ETAIL.
- ETAIL: emit TAIL with 7'h7F pad and 56'h0 data; go to HEAD. s_axis_tready=0 while in this state.

Buffering:
- Two registers: an assembly register and an output register.
- A completed assembly moves to the output register when it is empty or is being accepted in the same cycle.
- s_axis_tready=0 only when:
  - the assembly is complete and the output register holds an unaccepted flit, or
  - in reset, or
  - in ETAIL.

## Timing
- Reset: network_valid_o=0, network_flit_o=0, network_flit_type_o=00, s_axis_tready=0, state HEAD, byte_cnt=0. s_axis_tready goes to 1 in the first cycle after rst_noc deasserts.
- Reset mid-packet discards partial assembly and any pending flit.
- Latency: the flit completed by the byte accepted at edge N has network_valid_o=1 from cycle N+1.
- Throughput is one byte per cycle while network_ready_i is held at 1.
- network_valid_o, network_flit_o and network_flit_type_o hold stable until network_valid_o & network_ready_i. No combinational path from network_ready_i to network_flit_o.
- When an output transfer and a new assembly completion happen in the same cycle, the new flit is loaded with no bubble.
- ETAIL costs exactly one input stall cycle when the output is free.

## Structure
- Shared package network_data_pkg holds:
  - the flit type localparams HEADER, BODY, TAIL, HEADER_TAIL;
  - the field offsets and widths: pad, last, tid, tdest for header and tail;
  - header data byte count 4, body 8, tail 7.
- The downsizer uses the same package.
- Natural sub-module: noc_flit_out_reg, the output register with valid/ready hold logic.

## Test plan
- Reset behaviour: assert rst_noc for 3 cycles with s_axis_tvalid=1 → s_axis_tready=0 and network_valid_o=0 throughout; tready=1 the cycle after release.
- 3-byte packet: bytes 0x11,0x22,0x33 (last on 0x33), tid=5'h0A, tdest=11'h123 → one HEADER_TAIL flit with type 11, [31:0]=0x00332211, pad=4'b1000, bit36=1, tid field 0x0A, tdest field 0x123.
- 12-byte packet: bytes 0x01..0x0C → HEADER with bytes 01..04; BODY with bytes 05..0C; then ETAIL produces a TAIL with pad=7'h7F, last=1, data 0. Exactly one tready stall cycle.
- 7-byte packet: bytes 0x01..0x07 → HEADER with bytes 01..04; TAIL with bytes 05..07, pad=7'b1111000, last=1.
- Backpressure: hold network_ready_i=0 for 20 cycles during a 20-byte packet → flit fields stable while stalled, tready drops after the second flit completes, no byte lost or duplicated. A round-trip through network_data_axis_downsizer reproduces the original stream.
- tkeep handling with KeepEnable=1: beats (0xAA,keep1),(0xBB,keep0),(0xCC,keep1,last) → HEADER_TAIL with bytes AA,CC and pad=4'b1100. With KeepEnable=0, the same beats give bytes AA,BB,CC and pad=4'b1000.
